// File: rtl/code_patch_regs_if.sv
// Wishbone-classic register bus between the configuration master and code_patch_regs.
// wb_dat_w carries write data to the slave, wb_dat_r carries read data back.
interface code_patch_regs_if #(
  parameter int REG_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH     = 32
);
  logic                      wb_cyc;
  logic                      wb_stb;
  logic                      wb_we;
  logic [REG_ADDR_WIDTH-1:0] wb_adr;
  logic [DATA_WIDTH-1:0]     wb_dat_w;
  logic [DATA_WIDTH-1:0]     wb_dat_r;
  logic                      wb_ack;
  logic                      wb_err;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w,
    input  wb_dat_r, wb_ack, wb_err
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w,
    output wb_dat_r, wb_ack, wb_err
  );
endinterface

// File: rtl/code_patch_regs.sv
// Register slave for the code patch core: global config, per-entry match/substitute
// registers with enable/no-propagate bits, and saturating per-entry hit counters.
module code_patch_regs #(
  parameter int ADDR_WIDTH          = 32,
  parameter int DATA_WIDTH          = 32,
  parameter int NUM_REGS            = 8,
  parameter int SUB_REGS_DATA_WIDTH = 32,
  parameter int CNT_WIDTH           = 16,
  parameter int REG_ADDR_WIDTH      = 8
) (
  input  logic                                               clk_i,
  input  logic                                               rst_i,
  code_patch_regs_if.slave                                   wb,
  input  logic [NUM_REGS-1:0]                                patch_hit_i,
  output logic                                               cfg_pat_gen_o,
  output logic                                               cfg_addr_or_data_o,
  output logic [NUM_REGS-1:0][ADDR_WIDTH-1:0]                ctl_pat_addr_o,
  output logic [NUM_REGS-1:0][SUB_REGS_DATA_WIDTH-1:0]       ctl_pat_data_o,
  output logic [NUM_REGS-1:0]                                ctl_pat_pen_o,
  output logic [NUM_REGS-1:0]                                ctl_pat_nopg_o
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  logic [0:0]                                    state_q, state_d;
  logic                                          ack_q, ack_d;
  logic                                          err_q, err_d;
  logic [DATA_WIDTH-1:0]                         rdata_q, rdata_d;
  logic                                          gen_q, gen_d;
  logic                                          aod_q, aod_d;
  logic                                          lock_q, lock_d;
  logic [NUM_REGS-1:0]                           pen_q, pen_d;
  logic [NUM_REGS-1:0]                           nopg_q, nopg_d;
  logic [NUM_REGS-1:0][ADDR_WIDTH-1:0]           addr_q, addr_d;
  logic [NUM_REGS-1:0][SUB_REGS_DATA_WIDTH-1:0]  data_q, data_d;
  logic [NUM_REGS-1:0][CNT_WIDTH-1:0]            cnt_q, cnt_d;

  logic [REG_ADDR_WIDTH-1:0] adr_w;
  logic                      req;
  logic                      we;
  logic                      ok;
  logic                      hit_seen;
  logic [DATA_WIDTH-1:0]     rd;
  logic                      unused_adr_bits;

  assign adr_w           = {wb.wb_adr[REG_ADDR_WIDTH-1:2], 2'b00};
  assign unused_adr_bits = ^wb.wb_adr[1:0];
  assign req             = (state_q == ST_IDLE) & wb.wb_cyc & wb.wb_stb;
  assign we              = wb.wb_we;

  always_comb begin
    state_d  = ST_IDLE;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    gen_d    = gen_q;
    aod_d    = aod_q;
    lock_d   = lock_q;
    pen_d    = pen_q;
    nopg_d   = nopg_q;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    ok       = 1'b0;
    rd       = '0;
    hit_seen = 1'b0;

    // Only the lowest-index hit counts, mirroring the core's priority mux.
    for (int n = 0; n < NUM_REGS; n++) begin
      if (patch_hit_i[n] && !hit_seen) begin
        hit_seen = 1'b1;
        if (cnt_q[n] != {CNT_WIDTH{1'b1}}) cnt_d[n] = cnt_q[n] + CNT_WIDTH'(1);
      end
    end

    if (req) begin
      state_d = ST_RESP;
      if (adr_w == REG_ADDR_WIDTH'(0)) begin
        rd[0]  = gen_q;
        rd[1]  = aod_q;
        rd[31] = lock_q;
        ok     = !we || !lock_q;
        if (we && !lock_q) begin
          gen_d  = wb.wb_dat_w[0];
          aod_d  = wb.wb_dat_w[1];
          lock_d = wb.wb_dat_w[31];
        end
      end else if (adr_w == REG_ADDR_WIDTH'(4)) begin
        rd = DATA_WIDTH'(pen_q);
        ok = !we || !lock_q;
        if (we && !lock_q) pen_d = wb.wb_dat_w[NUM_REGS-1:0];
      end else if (adr_w == REG_ADDR_WIDTH'(8)) begin
        rd = DATA_WIDTH'(nopg_q);
        ok = !we || !lock_q;
        if (we && !lock_q) nopg_d = wb.wb_dat_w[NUM_REGS-1:0];
      end else if (adr_w == REG_ADDR_WIDTH'(12)) begin
        rd[0]    = lock_q;
        rd[15:8] = 8'(NUM_REGS);
        ok       = !we;
      end

      for (int n = 0; n < NUM_REGS; n++) begin
        if (adr_w == REG_ADDR_WIDTH'(64 + 16 * n)) begin
          rd = DATA_WIDTH'(addr_q[n]);
          ok = !we || (!lock_q && !pen_q[n]);
          if (we && !lock_q && !pen_q[n]) addr_d[n] = wb.wb_dat_w[ADDR_WIDTH-1:0];
        end else if (adr_w == REG_ADDR_WIDTH'(68 + 16 * n)) begin
          rd = DATA_WIDTH'(data_q[n]);
          ok = !we || (!lock_q && !pen_q[n]);
          if (we && !lock_q && !pen_q[n]) data_d[n] = wb.wb_dat_w[SUB_REGS_DATA_WIDTH-1:0];
        end else if (adr_w == REG_ADDR_WIDTH'(72 + 16 * n)) begin
          // A clear overrides any hit landing on the same edge.
          rd = DATA_WIDTH'(cnt_q[n]);
          ok = 1'b1;
          if (we) cnt_d[n] = '0;
        end
      end

      ack_d = ok;
      err_d = !ok;
      if (ok && !we) rdata_d = rd;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      gen_q   <= 1'b0;
      aod_q   <= 1'b0;
      lock_q  <= 1'b0;
      pen_q   <= '0;
      nopg_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      gen_q   <= gen_d;
      aod_q   <= aod_d;
      lock_q  <= lock_d;
      pen_q   <= pen_d;
      nopg_q  <= nopg_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb.wb_ack          = ack_q;
  assign wb.wb_err          = err_q;
  assign wb.wb_dat_r        = rdata_q;
  assign cfg_pat_gen_o      = gen_q;
  assign cfg_addr_or_data_o = aod_q;
  assign ctl_pat_pen_o      = pen_q;
  assign ctl_pat_nopg_o     = nopg_q;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_entry
    assign ctl_pat_addr_o[gi] = addr_q[gi];
    assign ctl_pat_data_o[gi] = data_q[gi];
  end
endmodule
